// File: rtl/uart_dbg_hex_pkg.sv
// Shared definitions for the uart_dbg_hex formatter: ASCII constants, FSM state type
// and the nibble-to-ASCII helper.
package uart_dbg_hex_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_x  = 8'h78;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PFX0  = 3'd1,
        ST_PFX1  = 3'd2,
        ST_DIGIT = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
    } state_t;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        logic [7:0] w;
        w = {4'h0, n};
        return (n < 4'd10) ? (ASCII_0 + w) : (ASCII_A + w - 8'd10);
    endfunction

endpackage

// File: rtl/uart_dbg_hex.sv
// Formats one binary word per handshake as "0x" + uppercase hex + CR/LF and streams
// the bytes into uart_dbg's wr/msg/full write port, stalling whenever full is high.
//
// state    | meaning
// ST_IDLE  | ready for a new word, no byte presented
// ST_PFX0  | presenting '0'
// ST_PFX1  | presenting 'x'
// ST_DIGIT | presenting top nibble of the shift register, cnt digits left
// ST_CR    | presenting carriage return
// ST_LF    | presenting line feed, last byte of the line
module uart_dbg_hex
    import uart_dbg_hex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          PREFIX_EN  = 1'b1,
    parameter bit          NEWLINE_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  wr,
    output logic [7:0]            msg,
    input  logic                  full
);

    localparam int unsigned NIBBLES = DATA_WIDTH / 4;
    localparam int unsigned CW      = $clog2(NIBBLES + 1);

    localparam state_t FIRST_ST     = PREFIX_EN  ? ST_PFX0 : ST_DIGIT;
    localparam state_t AFTER_DIGITS = NEWLINE_EN ? ST_CR   : ST_IDLE;

    generate
        if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_bad_width
            $error("uart_dbg_hex: DATA_WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  accept;
    logic                  consume;

    assign ready   = (state == ST_IDLE);
    assign accept  = valid && ready;
    assign wr      = !ready && !full;
    assign consume = wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Nothing moves unless a byte is actually taken, so a stall holds state, shreg and msg.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = FIRST_ST;
            shreg_nxt = data;
            cnt_nxt   = CW'(NIBBLES);
        end else if (consume) begin
            case (state)
                ST_PFX0: state_nxt = ST_PFX1;
                ST_PFX1: state_nxt = ST_DIGIT;
                ST_DIGIT: begin
                    shreg_nxt = shreg << 4;
                    cnt_nxt   = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = AFTER_DIGITS;
                    end
                end
                ST_CR:   state_nxt = ST_LF;
                ST_LF:   state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        msg = 8'h00;
        case (state)
            ST_PFX0:  msg = ASCII_0;
            ST_PFX1:  msg = ASCII_x;
            ST_DIGIT: msg = hex_to_ascii(shreg[DATA_WIDTH-1 -: 4]);
            ST_CR:    msg = ASCII_CR;
            ST_LF:    msg = ASCII_LF;
            default:  msg = 8'h00;
        endcase
    end

endmodule
